mc_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the single-issue CPU datapath. Fetches an instruction over an instruction-memory handshake, latches the opcode, then steps the datapath through EX/MEM/WB phases, asserting one phase's control signals per cycle. Owns the PC-write, IR-write and data-memory handshake, and paces multi-cycle multiplies. Replaces purely combinational opcode decode for the multi-cycle core variant.

---
 rtl/mc_ctrl_fsm.sv | 197 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: IF/ID/EX/MEM/WB phase control, PC/IR writes, data-memory handshake.
// Stalls in IF on imem_ready_i and in MEM on dmem_ready_i; multiply pacing is built only with MC_CTRL_MUL_EN.
module mc_ctrl_fsm #(
    parameter int unsigned MUL_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic [5:0] funct_i,
    input  logic       imem_ready_i,
    input  logic       dmem_ready_i,
    input  logic       branch_cond_i,
    output logic       imem_req_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic [3:0] alu_op_o,
    output logic [1:0] alu_src_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic [1:0] branch_type_o,
    output logic       mul_busy_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BGEZ = 6'b000001;
    localparam logic [5:0] OP_BNEZ = 6'b000101;
    localparam logic [5:0] OP_BGT  = 6'b000111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_IF   = 4'd1,
        S_ID   = 4'd2,
        S_EX   = 4'd3,
        S_MUL  = 4'd4,
        S_MEM  = 4'd5,
        S_WB   = 4'd6,
        S_BR   = 4'd7,
        S_JMP  = 4'd8
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] op_q;

    logic op_is_r, op_is_lw, op_is_sw, op_is_ex, op_is_br, op_is_j, op_is_mul;

    assign op_is_r  = (op_q == OP_R);
    assign op_is_lw = (op_q == OP_LW);
    assign op_is_sw = (op_q == OP_SW);
    assign op_is_ex = op_is_r || op_is_lw || op_is_sw ||
                      (op_q == OP_ADDI) || (op_q == OP_ORI) || (op_q == OP_LUI);
    assign op_is_br = (op_q == OP_BEQ) || (op_q == OP_BGEZ) ||
                      (op_q == OP_BNEZ) || (op_q == OP_BGT);
    assign op_is_j  = (op_q == OP_J);

`ifdef MC_CTRL_MUL_EN
    logic [5:0] funct_q;
    logic [4:0] mul_cnt_q;
    assign op_is_mul = op_is_r && (funct_q == 6'b011000);
`else
    logic unused_cfg;
    assign unused_cfg = ^{funct_i, MUL_LOAD};
    assign op_is_mul  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF:   if (imem_ready_i) state_d = S_ID;
            S_ID: begin
                if (op_is_mul)     state_d = S_MUL;
                else if (op_is_ex) state_d = S_EX;
                else if (op_is_br) state_d = S_BR;
                else if (op_is_j)  state_d = S_JMP;
                else               state_d = S_IF;
            end
            S_EX:   state_d = (op_is_lw || op_is_sw) ? S_MEM : S_WB;
`ifdef MC_CTRL_MUL_EN
            S_MUL:  if (mul_cnt_q == 5'd0) state_d = S_WB;
`endif
            S_MEM:  if (dmem_ready_i) state_d = op_is_lw ? S_WB : S_IF;
            S_WB, S_BR, S_JMP: state_d = S_IF;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
`ifdef MC_CTRL_MUL_EN
            funct_q   <= '0;
            mul_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == S_IF && imem_ready_i) begin
                op_q    <= instr_op_i;
`ifdef MC_CTRL_MUL_EN
                funct_q <= funct_i;
`endif
            end
`ifdef MC_CTRL_MUL_EN
            if (state_q == S_ID)
                mul_cnt_q <= MUL_LOAD;
            else if (state_q == S_MUL && mul_cnt_q != 5'd0)
                mul_cnt_q <= mul_cnt_q - 5'd1;
`endif
        end
    end

    // Decoded from state and latched opcode; the IF write pulses and the BR PC write
    // are qualified by their handshake/condition inputs in the same cycle.
    always_comb begin
        imem_req_o    = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        pc_src_o      = 2'b00;
        alu_op_o      = 4'b0000;
        alu_src_o     = 2'b00;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        reg_write_o   = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        branch_type_o = 2'b00;
        mul_busy_o    = 1'b0;
        illegal_o     = 1'b0;

        if (state_q == S_ID || state_q == S_EX || state_q == S_MUL ||
            state_q == S_MEM || state_q == S_WB) begin
            case (op_q)
                OP_R:         begin alu_op_o = 4'b0010; alu_src_o = 2'b00; end
                OP_ADDI:      begin alu_op_o = 4'b0100; alu_src_o = 2'b01; end
                OP_ORI:       begin alu_op_o = 4'b0101; alu_src_o = 2'b10; end
                OP_LUI:       begin alu_op_o = 4'b1000; alu_src_o = 2'b10; end
                OP_LW, OP_SW: begin alu_op_o = 4'b0000; alu_src_o = 2'b01; end
                OP_BEQ:       begin alu_op_o = 4'b0001; alu_src_o = 2'b00; end
                OP_BGEZ:      begin alu_op_o = 4'b1001; alu_src_o = 2'b00; end
                OP_BNEZ:      begin alu_op_o = 4'b1010; alu_src_o = 2'b00; end
                OP_BGT:       begin alu_op_o = 4'b1011; alu_src_o = 2'b00; end
                default:      begin alu_op_o = 4'b0000; alu_src_o = 2'b00; end
            endcase
        end

        case (state_q)
            S_IF: begin
                imem_req_o = 1'b1;
                ir_write_o = imem_ready_i;
                pc_write_o = imem_ready_i;
            end
            S_ID:  illegal_o = !(op_is_ex || op_is_br || op_is_j);
            S_MUL: mul_busy_o = 1'b1;
            S_MEM: begin
                mem_read_o  = op_is_lw;
                mem_write_o = op_is_sw;
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = op_is_r;
                mem_to_reg_o = op_is_lw;
            end
            S_BR: begin
                case (op_q)
                    OP_BGEZ: branch_type_o = 2'd1;
                    OP_BNEZ: branch_type_o = 2'd2;
                    OP_BGT:  branch_type_o = 2'd3;
                    default: branch_type_o = 2'd0;
                endcase
                pc_write_o = branch_cond_i;
                pc_src_o   = branch_cond_i ? 2'b01 : 2'b00;
            end
            S_JMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'b10;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected phase traces with random stalls and noise inputs.
module tb_mc_ctrl_fsm;

    localparam int MUL_CYCLES = 8;
`ifdef MC_CTRL_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam int K_R = 0, K_I = 1, K_MUL = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_J = 6, K_ILL = 7;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [3:0] alu_op;
        logic [1:0] alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] branch_type;
        logic       mul_busy;
        logic       illegal;
    } ctl_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] instr_op_i, funct_i;
    logic       imem_ready_i, dmem_ready_i, branch_cond_i;
    logic       imem_req_o, ir_write_o, pc_write_o;
    logic [1:0] pc_src_o, alu_src_o, branch_type_o;
    logic [3:0] alu_op_o, state_o;
    logic       reg_dst_o, mem_to_reg_o, reg_write_o, mem_read_o, mem_write_o;
    logic       mul_busy_o, illegal_o;

    mc_ctrl_fsm #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_op_i(instr_op_i), .funct_i(funct_i),
        .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i), .branch_cond_i(branch_cond_i),
        .imem_req_o(imem_req_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
        .pc_src_o(pc_src_o), .alu_op_o(alu_op_o), .alu_src_o(alu_src_o),
        .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .branch_type_o(branch_type_o),
        .mul_busy_o(mul_busy_o), .illegal_o(illegal_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    ctl_t obs;
    always_comb begin
        obs.imem_req    = imem_req_o;
        obs.ir_write    = ir_write_o;
        obs.pc_write    = pc_write_o;
        obs.pc_src      = pc_src_o;
        obs.alu_op      = alu_op_o;
        obs.alu_src     = alu_src_o;
        obs.reg_dst     = reg_dst_o;
        obs.mem_to_reg  = mem_to_reg_o;
        obs.reg_write   = reg_write_o;
        obs.mem_read    = mem_read_o;
        obs.mem_write   = mem_write_o;
        obs.branch_type = branch_type_o;
        obs.mul_busy    = mul_busy_o;
        obs.illegal     = illegal_o;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int instr_idx = 0;

    logic [5:0] legal_ops [0:10] = '{6'h00, 6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b,
                                     6'h04, 6'h01, 6'h05, 6'h07, 6'h02};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:               return (MUL_EN && fn == 6'b011000) ? K_MUL : K_R;
            6'h08, 6'h0d, 6'h0f: return K_I;
            6'h23:               return K_LW;
            6'h2b:               return K_SW;
            6'h04, 6'h01, 6'h05, 6'h07: return K_BR;
            6'h02:               return K_J;
            default:             return K_ILL;
        endcase
    endfunction

    // {alu_op, alu_src} per opcode
    function automatic logic [5:0] alu_of(input logic [5:0] op);
        case (op)
            6'h00:        return 6'b0010_00;
            6'h08:        return 6'b0100_01;
            6'h0d:        return 6'b0101_10;
            6'h0f:        return 6'b1000_10;
            6'h23, 6'h2b: return 6'b0000_01;
            6'h04:        return 6'b0001_00;
            6'h01:        return 6'b1001_00;
            6'h05:        return 6'b1010_00;
            6'h07:        return 6'b1011_00;
            default:      return 6'b0000_00;
        endcase
    endfunction

    function automatic logic [1:0] bt_of(input logic [5:0] op);
        case (op)
            6'h01:   return 2'd1;
            6'h05:   return 2'd2;
            6'h07:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // One cycle: drive inputs just after the edge, compare at the falling edge.
    task automatic step(input logic ir, input logic dr, input logic bc,
                        input logic [5:0] op, input logic [5:0] fn,
                        input ctl_t e, input string tag, input bit chk_idle);
        imem_ready_i  = ir;
        dmem_ready_i  = dr;
        branch_cond_i = bc;
        instr_op_i    = op;
        funct_i       = fn;
        @(negedge clk_i);
        check($sformatf("%s#%0d", tag, instr_idx), 32'(obs), 32'(e));
        if (chk_idle) check($sformatf("idle_state#%0d", instr_idx), 32'(state_o), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wi,
                             input int wd, input logic bc, input bit idle_first);
        ctl_t e, base;
        int   k;
        k = kind_of(op, fn);
        instr_idx++;
        if (idle_first) begin
            e = '0;
            step(rb(), rb(), rb(), r6(), r6(), e, "idle", 1'b1);
        end
        for (int i = 0; i < wi; i++) begin
            e = '0; e.imem_req = 1'b1;
            step(1'b0, rb(), rb(), r6(), r6(), e, "if_wait", 1'b0);
        end
        e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(1'b1, rb(), rb(), op, fn, e, "if_fetch", 1'b0);

        base = '0;
        {base.alu_op, base.alu_src} = alu_of(op);
        e = base; e.illegal = (k == K_ILL);
        step(rb(), rb(), rb(), r6(), r6(), e, "id", 1'b0);

        if (k == K_R || k == K_I || k == K_LW || k == K_SW) begin
            e = base;
            step(rb(), rb(), rb(), r6(), r6(), e, "ex", 1'b0);
        end
        if (k == K_MUL) begin
            for (int i = 0; i < MUL_CYCLES; i++) begin
                e = base; e.mul_busy = 1'b1;
                step(rb(), rb(), rb(), r6(), r6(), e, "mul", 1'b0);
            end
        end
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= wd; i++) begin
                e = base; e.mem_read = (k == K_LW); e.mem_write = (k == K_SW);
                step(rb(), (i == wd), rb(), r6(), r6(), e, "mem", 1'b0);
            end
        end
        if (k == K_R || k == K_I || k == K_MUL || k == K_LW) begin
            e = base; e.reg_write = 1'b1;
            e.reg_dst = (k == K_R || k == K_MUL);
            e.mem_to_reg = (k == K_LW);
            step(rb(), rb(), rb(), r6(), r6(), e, "wb", 1'b0);
        end
        if (k == K_BR) begin
            e = '0; e.branch_type = bt_of(op);
            e.pc_write = bc; e.pc_src = bc ? 2'b01 : 2'b00;
            step(rb(), rb(), bc, r6(), r6(), e, "br", 1'b0);
        end
        if (k == K_J) begin
            e = '0; e.pc_write = 1'b1; e.pc_src = 2'b10;
            step(rb(), rb(), rb(), r6(), r6(), e, "jmp", 1'b0);
        end
    endtask

    initial begin
        ctl_t e;
        rst_i = 1'b0;
        imem_ready_i = 1'b1; dmem_ready_i = 1'b1; branch_cond_i = 1'b1;
        instr_op_i = 6'h23; funct_i = 6'h18;
        #3;
        check("reset_outs", 32'(obs), 32'd0);
        check("reset_state", 32'(state_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_hold_outs", 32'(obs), 32'd0);
        rst_i = 1'b1;

        run_instr(6'h08, 6'h00, 0, 0, 1'b0, 1'b1);   // addi straight after reset
        run_instr(6'h23, 6'h00, 0, 3, 1'b0, 1'b0);   // lw, three dmem wait cycles
        run_instr(6'h05, 6'h00, 0, 0, 1'b1, 1'b0);   // bnez taken
        run_instr(6'h05, 6'h00, 0, 0, 1'b0, 1'b0);   // bnez not taken
        run_instr(6'h00, 6'h18, 0, 0, 1'b0, 1'b0);   // mult
        run_instr(6'h3f, 6'h00, 0, 0, 1'b0, 1'b0);   // undefined opcode
        run_instr(6'h2b, 6'h00, 2, 1, 1'b0, 1'b0);   // sw with fetch and memory stalls
        run_instr(6'h02, 6'h00, 1, 0, 1'b0, 1'b0);   // j

        for (int n = 0; n < 200; n++) begin
            int         sel;
            logic [5:0] op, fn;
            sel = $urandom_range(0, 11);
            op  = (sel == 11) ? r6() : legal_ops[sel];
            fn  = ($urandom_range(0, 2) == 0) ? 6'b011000 : r6();
            run_instr(op, fn,
                      ($urandom_range(0, 3) > 1) ? $urandom_range(1, 3) : 0,
                      $urandom_range(0, 3), rb(), 1'b0);
        end

        // Reset while sw is stalled in MEM: the write request must drop at once.
        instr_idx++;
        e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(1'b1, 1'b0, 1'b0, 6'h2b, 6'h00, e, "rst_sw_fetch", 1'b0);
        e = '0; {e.alu_op, e.alu_src} = alu_of(6'h2b);
        step(1'b0, 1'b0, 1'b0, r6(), r6(), e, "rst_sw_id", 1'b0);
        step(1'b0, 1'b0, 1'b0, r6(), r6(), e, "rst_sw_ex", 1'b0);
        e.mem_write = 1'b1;
        step(1'b0, 1'b0, 1'b0, r6(), r6(), e, "rst_sw_mem", 1'b0);
        step(1'b0, 1'b0, 1'b0, r6(), r6(), e, "rst_sw_mem", 1'b0);
        dmem_ready_i = 1'b0;
        #2;
        check("rst_pre_memw", 32'(mem_write_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check("rst_async_outs", 32'(obs), 32'd0);
        check("rst_async_state", 32'(state_o), 32'd0);
        dmem_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_held_outs", 32'(obs), 32'd0);
        rst_i = 1'b1;
        run_instr(6'h0d, 6'h00, 0, 0, 1'b0, 1'b1);
        run_instr(6'h0f, 6'h00, 1, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
